// File: rtl/sha256_id_issuer.sv
// Arbitrating ID issuer for the SHA-256 ID buffer: packet-locked round-robin
// across message sources, sequential ID stamping and an in-flight message limit.
module sha256_id_issuer #(
  parameter int  NUM_REQ         = 2,
  parameter int  ID_W            = 6,
  parameter int  MAX_OUTSTANDING = 8,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1),
  localparam int IDX_W           = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               sync_rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id_out,
  output logic               id_out_last,
  output logic               id_out_valid,
  input  logic               id_out_ready,
  input  logic               retire_valid,
  output logic [OUT_W-1:0]   outstanding,
  output logic               busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W:0]   cand;
  logic             issue;
  logic             retire_dec;

  // Round-robin search starting just after the previous owner, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant_q} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
        cand = cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (!sel_found && req_valid[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    grant        = '0;
    req_ready    = '0;
    id_out       = '0;
    id_out_last  = 1'b0;
    id_out_valid = 1'b0;
    issue        = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && sel_found) begin
          state_d = LOCKED;
          owner_d = sel_idx;
          issue   = 1'b1;
        end
      end
      LOCKED: begin
        grant[owner_q]     = 1'b1;
        id_out             = cur_id_q;
        id_out_last        = req_last[owner_q];
        id_out_valid       = req_valid[owner_q] & en;
        req_ready[owner_q] = id_out_ready & en;
        if (id_out_valid && id_out_ready && id_out_last) begin
          cur_id_d     = cur_id_q + ID_W'(1);
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Retires count even while disabled; a retire at zero is dropped.
  always_comb begin
    retire_dec    = retire_valid && (outstanding_q != '0);
    outstanding_d = outstanding_q;
    if (issue && !retire_dec) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!issue && retire_dec) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      cur_id_q      <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cur_id_q      <= cur_id_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign outstanding = outstanding_q;
  assign busy        = (state_q == LOCKED);

endmodule
